// File: rtl/cpu_sys_pkg.sv
// Shared types and sizes for the accumulator CPU system: boot FSM states
// and the 64x8 RAM geometry.
package cpu_sys_pkg;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 64;

    localparam logic [ADDR_W-1:0] LAST_ADDR = 6'd63;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FILL    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } boot_state_t;

endpackage

// File: rtl/cpu_boot_ctrl.sv
// Boot/run controller: streams a program image into RAM, then releases the CPU.
// Optional macro RAM_ZERO_FILL_EN zero-fills the RAM tail after a short image.
module cpu_boot_ctrl
    import cpu_sys_pkg::*;
#(
    parameter int MAX_CYCLES = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              halt,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rw,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              running,
    output logic              timeout,
    output logic [CNT_W-1:0]  run_cycles
);

    boot_state_t       state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              cpu_reset_r;
    logic              timeout_r;
    logic [CNT_W-1:0]  run_cycles_r;

    logic              xfer_s;
    logic              load_end_s;
    logic              budget_hit_s;
    logic [CNT_W-1:0]  run_cycles_inc_s;

    assign xfer_s           = ld_valid && (state_r == ST_LOAD);
    assign load_end_s       = xfer_s && (ld_last || (ptr_r == LAST_ADDR));
    assign budget_hit_s     = (MAX_CYCLES != 0) && (run_cycles_r == CNT_W'(MAX_CYCLES - 1));
    assign run_cycles_inc_s = (run_cycles_r == {CNT_W{1'b1}}) ? run_cycles_r
                                                              : run_cycles_r + CNT_W'(1);

    // Boot FSM with registered CPU reset, load pointer, budget counter and sticky timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_HOLD;
            ptr_r        <= '0;
            cpu_reset_r  <= 1'b1;
            timeout_r    <= 1'b0;
            run_cycles_r <= '0;
        end else begin
            if (load_start || run_start) begin
                timeout_r <= 1'b0;
            end
            case (state_r)
                ST_HOLD: begin
                    cpu_reset_r <= 1'b1;
                    if (load_start) begin
                        state_r <= ST_LOAD;
                        ptr_r   <= '0;
                    end else if (run_start) begin
                        state_r <= ST_RELEASE;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        ptr_r <= ptr_r + 6'd1;
                    end
                    if (halt) begin
                        state_r <= ST_HOLD;
                    end else if (load_end_s) begin
`ifdef RAM_ZERO_FILL_EN
                        state_r <= (ptr_r == LAST_ADDR) ? ST_HOLD : ST_FILL;
`else
                        state_r <= ST_HOLD;
`endif
                    end
                end
`ifdef RAM_ZERO_FILL_EN
                ST_FILL: begin
                    ptr_r <= ptr_r + 6'd1;
                    if (halt || (ptr_r == LAST_ADDR)) begin
                        state_r <= ST_HOLD;
                    end
                end
`endif
                ST_RELEASE: begin
                    if (halt) begin
                        state_r <= ST_HOLD;
                    end else begin
                        cpu_reset_r  <= 1'b0;
                        run_cycles_r <= '0;
                        state_r      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    run_cycles_r <= run_cycles_inc_s;
                    if (halt) begin
                        cpu_reset_r <= 1'b1;
                        state_r     <= ST_HOLD;
                    end else if (load_start) begin
                        cpu_reset_r <= 1'b1;
                        ptr_r       <= '0;
                        state_r     <= ST_LOAD;
                    end else if (budget_hit_s) begin
                        timeout_r   <= 1'b1;
                        cpu_reset_r <= 1'b1;
                        state_r     <= ST_HOLD;
                    end
                end
                default: begin
                    cpu_reset_r <= 1'b1;
                    state_r     <= ST_HOLD;
                end
            endcase
        end
    end

    // RAM port ownership: loader/filler outside RUN, CPU pass-through in RUN.
    always_comb begin
        mem_addr  = ptr_r;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        case (state_r)
            ST_LOAD: begin
                mem_we    = ld_valid;
                mem_wdata = ld_data;
            end
`ifdef RAM_ZERO_FILL_EN
            ST_FILL: begin
                mem_we = 1'b1;
            end
`endif
            ST_RUN: begin
                // a reload request already fences the CPU off the RAM this cycle
                mem_addr  = cpu_addr;
                mem_we    = ~cpu_rw & ~load_start;
                mem_wdata = cpu_wdata;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign cpu_rdata  = mem_rdata;
    assign ld_ready   = (state_r == ST_LOAD);
    assign busy       = (state_r == ST_LOAD) || (state_r == ST_FILL) || (state_r == ST_RELEASE);
    assign running    = (state_r == ST_RUN);
    assign cpu_reset  = cpu_reset_r;
    assign timeout    = timeout_r;
    assign run_cycles = run_cycles_r;

endmodule
